// File: rtl/sigma_iop_if.sv
// Purpose: CPU command port and memory read-data/grant signals of the Sigma IOP.
// Latency: n/a (signal bundle only).
// Backpressure: none; the bus grant (active) gates all IOP memory traffic.
interface sigma_iop_if;
   logic        active;           // bus grant, 1 = IOP owns the memory bus
   logic [0:31] memory_data_out;  // read data, valid the cycle after the address
   logic [0:2]  iop_func;         // I/O function code from the CPU
   logic [0:2]  iop_addr;         // device number
   logic [0:1]  iop_cc;           // condition code back to the CPU

   modport master (
      output active,
      output memory_data_out,
      output iop_func,
      output iop_addr,
      input  iop_cc
   );

   modport slave (
      input  active,
      input  memory_data_out,
      input  iop_func,
      input  iop_addr,
      output iop_cc
   );
endinterface

// File: rtl/sigma_iop.sv
// Purpose: 8-channel I/O processor; services busy devices by writing count words to a memory buffer.
// Latency: command cc on the sampling edge; 4 cycles from SIO to the first buffer write, then 1 word/cycle.
// Backpressure: the transfer FSM freezes while active=0 and the memory pins float.
module sigma_iop (
   input  logic        clock,
   input  logic        reset,
   sigma_iop_if.slave  bus,
   // Tristate memory pins stay plain ports so the resolved net lives outside the IOP.
   output wire [15:31] memory_address,
   output wire [0:31]  memory_data_in,
   output wire [0:3]   mem_write_en
);

   typedef enum logic [2:0] {
      S_IDLE,
      S_CMD0,
      S_CMD1,
      S_CMDW,
      S_XFER
   } state_t;

   localparam logic [0:2] F_SIO = 3'd1;
   localparam logic [0:2] F_TIO = 3'd2;
   localparam logic [0:2] F_TDV = 3'd3;
   localparam logic [0:2] F_HIO = 3'd4;

   state_t      state_q, state_d;
   logic [7:0]  busy_q,  busy_d;
   logic [1:0]  cc_q,    cc_d;
   logic [2:0]  dev_q,   dev_d;
   logic [16:0] buf_q,   buf_d;
   logic [15:0] cnt_q,   cnt_d;
   logic [15:0] idx_q,   idx_d;

   logic [7:0]  sio_set;    // device started by this edge's SIO
   logic [7:0]  hio_clr;    // device halted by this edge's HIO
   logic [7:0]  done_clr;   // device finished by the transfer FSM
   logic [7:0]  sel_mask;   // candidates for the next transfer

   logic [16:0] addr_c;
   logic [0:31] data_c;
   logic [0:3]  we_c;

   // High bits of read data carry nothing for the command words.
   logic unused_rd_bits;
   assign unused_rd_bits = &{1'b0, bus.memory_data_out[0:14]};

   // Command decode: cc is always judged against the pre-edge busy flags.
   always_comb begin
      cc_d    = cc_q;
      sio_set = '0;
      hio_clr = '0;
      case (bus.iop_func)
         F_SIO: begin
            cc_d = busy_q[bus.iop_addr] ? 2'b01 : 2'b00;
            if (!busy_q[bus.iop_addr]) sio_set[bus.iop_addr] = 1'b1;
         end
         F_TIO, F_TDV: begin
            cc_d = busy_q[bus.iop_addr] ? 2'b01 : 2'b00;
         end
         F_HIO: begin
            cc_d = busy_q[bus.iop_addr] ? 2'b01 : 2'b00;
            if (busy_q[bus.iop_addr]) hio_clr[bus.iop_addr] = 1'b1;
         end
         default: ;
      endcase
   end

   assign sel_mask = busy_q & ~hio_clr;

   // Transfer FSM next state and bus drive values.
   always_comb begin
      state_d  = state_q;
      dev_d    = dev_q;
      buf_d    = buf_q;
      cnt_d    = cnt_q;
      idx_d    = idx_q;
      done_clr = '0;
      addr_c   = '0;
      data_c   = '0;
      we_c     = '0;

      case (state_q)
         S_CMD0: addr_c = 17'h20 + {13'b0, dev_q, 1'b0};
         S_CMD1: addr_c = 17'h21 + {13'b0, dev_q, 1'b0};
         S_XFER: begin
            addr_c = buf_q + {1'b0, idx_q};
            data_c = {dev_q, 13'b0, idx_q};
            we_c   = 4'hF;
         end
         default: ;
      endcase

      if (bus.active) begin
         case (state_q)
            S_IDLE: begin
               // Lowest-numbered busy device wins.
               for (int k = 7; k >= 0; k--) begin
                  if (sel_mask[k]) dev_d = 3'(k);
               end
               if (|sel_mask) state_d = S_CMD0;
            end
            S_CMD0: state_d = S_CMD1;
            S_CMD1: begin
               buf_d   = bus.memory_data_out[15:31];
               state_d = S_CMDW;
            end
            S_CMDW: begin
               cnt_d = bus.memory_data_out[16:31];
               if (bus.memory_data_out[16:31] == 16'd0) begin
                  done_clr[dev_q] = 1'b1;
                  state_d         = S_IDLE;
               end else begin
                  idx_d   = '0;
                  state_d = S_XFER;
               end
            end
            S_XFER: begin
               if (idx_q == cnt_q - 16'd1) begin
                  done_clr[dev_q] = 1'b1;
                  state_d         = S_IDLE;
               end else begin
                  idx_d = idx_q + 16'd1;
               end
            end
            default: state_d = S_IDLE;
         endcase
      end

      // A halted device loses its channel at once, even while the bus is not granted,
      // so a frozen transfer can never resume on an idle device.
      if (state_q != S_IDLE && hio_clr[dev_q]) state_d = S_IDLE;
   end

   // Completion is applied before the SIO start; they can never name the same device.
   assign busy_d = (busy_q & ~done_clr & ~hio_clr) | sio_set;

   // State registers with asynchronous reset.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state_q <= S_IDLE;
         busy_q  <= '0;
         cc_q    <= '0;
         dev_q   <= '0;
         buf_q   <= '0;
         cnt_q   <= '0;
         idx_q   <= '0;
      end else begin
         state_q <= state_d;
         busy_q  <= busy_d;
         cc_q    <= cc_d;
         dev_q   <= dev_d;
         buf_q   <= buf_d;
         cnt_q   <= cnt_d;
         idx_q   <= idx_d;
      end
   end

   assign bus.iop_cc      = cc_q;
   assign memory_address  = bus.active ? addr_c : {17{1'bz}};
   assign memory_data_in  = bus.active ? data_c : {32{1'bz}};
   assign mem_write_en    = bus.active ? we_c   : {4{1'bz}};

endmodule

// File: tb/tb_sigma_iop.sv
// Purpose: scoreboard bench for sigma_iop with a word-addressed memory model on the shared bus.
// Latency: expected writes are queued at command time and retired as the IOP drives them.
// Backpressure: the bench toggles the bus grant to freeze and release the IOP.
module tb_sigma_iop;

   logic clock = 1'b0;
   logic reset;

   always #5 clock = ~clock;

   sigma_iop_if bus ();

   // Pulled-up nets: a floating IOP pin reads as all ones.
   tri1 [15:31] memory_address;
   tri1 [0:31]  memory_data_in;
   tri1 [0:3]   mem_write_en;

   sigma_iop dut (
      .clock          (clock),
      .reset          (reset),
      .bus            (bus),
      .memory_address (memory_address),
      .memory_data_in (memory_data_in),
      .mem_write_en   (mem_write_en)
   );

   typedef struct packed {
      logic [16:0] addr;
      logic [31:0] data;
   } wr_t;

   wr_t         exp_q[$];
   logic [0:31] mem [0:131071];
   int          n_tests  = 0;
   int          n_fail   = 0;
   int          wr_count = 0;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_tests++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Memory model: registered read, full-word write, only while the IOP holds the bus.
   always @(posedge clock) begin
      if (bus.active === 1'b1) begin
         bus.memory_data_out <= mem[memory_address];
         if (mem_write_en === 4'hF) mem[memory_address] = memory_data_in;
      end
   end

   // Write monitor: sees what the IOP will write on the coming edge.
   always @(negedge clock) begin
      wr_t e;
      #2;
      if (bus.active === 1'b1 && reset === 1'b0 && mem_write_en !== 4'h0) begin
         wr_count++;
         chk("wr_en", 64'(mem_write_en), 64'hF);
         chk("wr_expected", 64'(exp_q.size() != 0), 64'd1);
         if (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            chk("wr_addr", 64'(memory_address), 64'(e.addr));
            chk("wr_data", 64'(memory_data_in), 64'(e.data));
         end
      end
   end

   task automatic set_cmd(input int d, input logic [16:0] b, input logic [15:0] n);
      mem[32 + 2 * d] = {15'b0, b};
      mem[33 + 2 * d] = {16'b0, n};
   endtask

   task automatic push_xfer(input int d, input logic [16:0] b, input int n);
      for (int i = 0; i < n; i++) begin
         wr_t w;
         w.addr = b + 17'(i);
         w.data = {3'(d), 13'b0, 16'(i)};
         exp_q.push_back(w);
      end
   endtask

   task automatic cmd(input logic [2:0] f, input logic [2:0] d, input logic [1:0] exp, input string tag);
      bus.iop_func = f;
      bus.iop_addr = d;
      @(posedge clock);
      #1;
      bus.iop_func = 3'd0;
      chk(tag, 64'(bus.iop_cc), 64'(exp));
   endtask

   task automatic wait_wr(input int target, input string tag);
      int k = 0;
      while (wr_count < target && k < 200) begin
         @(negedge clock);
         #3;
         k++;
      end
      chk(tag, 64'(wr_count >= target), 64'd1);
   endtask

   task automatic wait_drain(input string tag);
      int k = 0;
      while (exp_q.size() != 0 && k < 300) begin
         @(negedge clock);
         #3;
         k++;
      end
      chk(tag, 64'(exp_q.size()), 64'd0);
      repeat (3) @(negedge clock);
      #3;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int wr0;
      int written;
      for (int i = 0; i < 131072; i++) mem[i] = '0;
      reset        = 1'b1;
      bus.active   = 1'b1;
      bus.iop_func = 3'd0;
      bus.iop_addr = 3'd0;

      // Reset state, bus granted then released.
      #12;
      chk("rst_cc",   64'(bus.iop_cc),      64'd0);
      chk("rst_addr", 64'(memory_address),  64'd0);
      chk("rst_data", 64'(memory_data_in),  64'd0);
      chk("rst_we",   64'(mem_write_en),    64'd0);
      bus.active = 1'b0;
      #1;
      chk("rst_hiz_addr", 64'(memory_address), 64'h1FFFF);
      chk("rst_hiz_data", 64'(memory_data_in), 64'hFFFF_FFFF);
      chk("rst_hiz_we",   64'(mem_write_en),   64'hF);
      bus.active = 1'b1;
      @(negedge clock);
      reset = 1'b0;

      // Basic transfer on device 2.
      set_cmd(2, 17'h100, 16'd3);
      push_xfer(2, 17'h100, 3);
      cmd(3'd1, 3'd2, 2'b00, "sio2");
      wait_drain("sio2_drain");
      chk("mem_100", 64'(mem[17'h100]), 64'h4000_0000);
      chk("mem_101", 64'(mem[17'h101]), 64'h4000_0001);
      chk("mem_102", 64'(mem[17'h102]), 64'h4000_0002);
      cmd(3'd2, 3'd2, 2'b00, "tio2_after");

      // Commands accepted without the bus; no traffic until the grant returns.
      bus.active = 1'b0;
      cmd(3'd1, 3'd2, 2'b00, "sio2_inact_a");
      cmd(3'd1, 3'd2, 2'b01, "sio2_inact_b");
      repeat (6) @(negedge clock);
      #3;
      chk("inact_hiz_addr", 64'(memory_address), 64'h1FFFF);
      chk("inact_hiz_we",   64'(mem_write_en),   64'hF);
      push_xfer(2, 17'h100, 3);
      bus.active = 1'b1;
      wait_drain("inact_drain");

      // Zero count: device released at CMDW without writing.
      set_cmd(5, 17'h300, 16'd0);
      cmd(3'd1, 3'd5, 2'b00, "sio5");
      repeat (10) @(negedge clock);
      cmd(3'd3, 3'd5, 2'b00, "tdv5_idle");
      chk("mem_300", 64'(mem[17'h300]), 64'd0);

      // Halt device 1 after three writes.
      set_cmd(1, 17'h400, 16'd10);
      push_xfer(1, 17'h400, 4);
      wr0 = wr_count;
      cmd(3'd1, 3'd1, 2'b00, "sio1");
      wait_wr(wr0 + 3, "hio_wait3");
      cmd(3'd4, 3'd1, 2'b01, "hio1_cc");
      repeat (15) @(negedge clock);
      #3;
      written = wr_count - wr0;
      chk("hio_words_3or4", 64'(written == 3 || written == 4), 64'd1);
      chk("hio_mem_404", 64'(mem[17'h404]), 64'd0);
      exp_q.delete();
      cmd(3'd2, 3'd1, 2'b00, "tio1_after_hio");

      // Priority: device 3 runs to completion before device 6.
      bus.active = 1'b0;
      set_cmd(3, 17'h500, 16'd2);
      set_cmd(6, 17'h600, 16'd2);
      cmd(3'd1, 3'd6, 2'b00, "sio6");
      cmd(3'd1, 3'd3, 2'b00, "sio3");
      push_xfer(3, 17'h500, 2);
      push_xfer(6, 17'h600, 2);
      bus.active = 1'b1;
      wait_drain("prio_drain");
      cmd(3'd2, 3'd3, 2'b00, "tio3_done");
      cmd(3'd2, 3'd6, 2'b00, "tio6_done");

      // SIO landing on the completion edge still sees the device busy.
      set_cmd(4, 17'h800, 16'd1);
      push_xfer(4, 17'h800, 1);
      wr0 = wr_count;
      cmd(3'd1, 3'd4, 2'b00, "sio4");
      wait_wr(wr0 + 1, "same_edge_wait");
      cmd(3'd1, 3'd4, 2'b01, "sio4_same_edge");
      repeat (3) @(negedge clock);
      cmd(3'd2, 3'd4, 2'b00, "tio4_idle");

      // Buffer address wraps past the top of memory.
      set_cmd(7, 17'h1FFFF, 16'd2);
      push_xfer(7, 17'h1FFFF, 2);
      cmd(3'd1, 3'd7, 2'b00, "sio7");
      wait_drain("wrap_drain");
      chk("mem_wrap_0", 64'(mem[17'h00000]), 64'hE000_0001);

      // Reset in the middle of a transfer.
      set_cmd(0, 17'h700, 16'd20);
      push_xfer(0, 17'h700, 2);
      wr0 = wr_count;
      cmd(3'd1, 3'd0, 2'b00, "sio0");
      wait_wr(wr0 + 2, "rst_mid_wait");
      reset = 1'b1;
      @(negedge clock);
      #3;
      chk("rst_mid_addr", 64'(memory_address), 64'd0);
      chk("rst_mid_we",   64'(mem_write_en),   64'd0);
      reset = 1'b0;
      repeat (30) @(negedge clock);
      #3;
      chk("rst_mid_q", 64'(exp_q.size()), 64'd0);
      chk("rst_mid_mem_701", 64'(mem[17'h701]), 64'd0);
      cmd(3'd2, 3'd0, 2'b00, "tio0_after_rst");

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/sigma_iop.md
SIGMA_IOP -- requirements
Module: sigma_iop

Interface
REQ-001 The module SHALL have no parameters.
REQ-002 reset  in  1  asynchronous, active-high reset.
REQ-003 clock  in  1  single clock; all state changes on its rising edge.
REQ-004 active  in  1  bus grant; 1 = IOP owns the shared memory bus.
REQ-005 memory_address  out  17 [15:31]  word address; high-Z when active=0.
REQ-006 memory_data_out  in  32 [0:31]  memory read data, valid the cycle after the address is presented.
REQ-007 memory_data_in  out  32 [0:31]  memory write data; high-Z when active=0.
REQ-008 mem_write_en  out  4 [0:3]  byte write enables, bit 0 = bits 0:7; high-Z when active=0.
REQ-009 iop_func  in  3 [0:2]  I/O function from the CPU: 0 none, 1 SIO, 2 TIO, 3 TDV, 4 HIO, 5-7 none.
REQ-010 iop_addr  in  3 [0:2]  device number 0-7.
REQ-011 iop_cc  out  2 [0:1]  condition code returned to the CPU; always driven.

Function
REQ-012 The IOP SHALL hold 8 device channels, each idle or busy.
REQ-013 A nonzero func SHALL be sampled on a clock edge regardless of active; iop_cc updates on that edge and holds until the next nonzero func.
REQ-014 SIO on an idle device SHALL set cc=00 and mark it busy; SIO on a busy device SHALL set cc=01 and change nothing.
REQ-015 TIO and TDV SHALL set cc=00 for an idle device and 01 for a busy device, with no state change.
REQ-016 HIO SHALL set cc=00 for an idle device; for a busy device it SHALL set cc=01 and force the device idle, aborting any transfer in progress on it at the next edge.
REQ-017 With active=0, the transfer FSM SHALL freeze in its current state, and the outputs in REQ-005, REQ-007 and REQ-008 SHALL be high-Z.
REQ-018 With active=1 and FSM in IDLE, the IOP SHALL drive address 0, data 0, and write_en 0000.
REQ-019 FSM states: IDLE, CMD0, CMD1, CMDW, XFER. The FSM advances only when active=1.
REQ-020 IDLE: if any device is busy, select the lowest-numbered busy device d and go to CMD0.
REQ-021 CMD0: drive address 0x20+2d, then go to CMD1.
REQ-022 CMD1: drive address 0x21+2d, capture memory_data_out[15:31] as the buffer address, then go to CMDW.
REQ-023 CMDW: capture memory_data_out[16:31] as the word count N; if N=0, mark d idle and return to IDLE, otherwise go to XFER with index i=0.
REQ-024 XFER: each cycle drive address = buffer+i with write_en=1111 and data = {d in bits 0:2, zeros in bits 3:15, i in bits 16:31}, then increment i.
REQ-025 After the write with i=N-1, the FSM SHALL mark d idle and go to IDLE.
REQ-026 Buffer address arithmetic SHALL wrap modulo 2^17.
REQ-027 An SIO to a device that completes on the same edge SHALL see the device as busy (cc=01); completion takes effect after command sampling.
REQ-028 A HIO on the device currently in transfer SHALL stop writes from the next cycle, and the FSM SHALL return to IDLE.

Reset
REQ-029 On reset: all devices idle, FSM=IDLE, iop_cc=00, i=0, and captured buffer address and count cleared.
REQ-030 Reset asserted mid-transfer SHALL abort the transfer with no further writes.
REQ-031 During reset, the bus outputs SHALL follow active per REQ-017 and REQ-018.

Verification
REQ-032 Reset with active=1 -> iop_cc=00, address 0, write_en 0000; with active=0 -> the three bus outputs are Z.
REQ-033 Memory[0x24]=0x100 and [0x25]=3; SIO dev2 with active=1 -> cc=00; words 0x100..0x102 become 0x40000000, 0x40000001, 0x40000002; TIO dev2 afterwards -> cc=00.
REQ-034 SIO dev2 twice on consecutive cycles with active=0 -> cc=00 then 01; no bus activity until active=1.
REQ-035 Count 0 for dev5; SIO dev5 -> device idle after CMDW with no writes; TDV dev5 -> cc=00.
REQ-036 Start dev1 with count 10 and issue HIO dev1 after 3 writes -> cc=01, exactly 3 or 4 words written (per REQ-016), device idle.
REQ-037 Devices 3 and 6 both busy -> dev3 is serviced completely before dev6.
